// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter that lends one shared tristate pad group to NREQ requesters,
// with hi-Z turnaround between owners. Define TRI_BUS_TIMEOUT_EN to cap each grant at MAXHOLD cycles.
module tri_bus_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int TURN    = 2,
   parameter int MAXHOLD = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] dat,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      pad_i,
   output logic                  pad_t,
   output logic                  busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_TURN
   } state_e;

   state_e              state_q;
   logic [NREQ-1:0]     gnt_q;
   logic [WIDTH-1:0]    pad_i_q;
   logic                pad_t_q;
   logic                busy_q;
   logic [IW-1:0]       last_q;
   logic [TW-1:0]       turn_q;

   logic [WIDTH-1:0]    dat_a [NREQ];
   logic [IW-1:0]       win_idx_d;
   logic                win_vld_d;
   logic                drive_stop;

   for (genvar n = 0; n < NREQ; n++) begin : g_dat
      assign dat_a[n] = dat[n*WIDTH +: WIDTH];
   end

`ifdef TRI_BUS_TIMEOUT_EN
   logic [7:0] hold_q;
   assign drive_stop = !req[last_q] || (hold_q == 8'(MAXHOLD));
`else
   assign drive_stop = !req[last_q];
`endif

   // Walk downward from the farthest candidate so the nearest requester after last_q wins.
   always_comb begin : rr_search
      int unsigned cand;
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cand      = 0;
      win_idx_d = '0;
      win_vld_d = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = (int'(last_q) + k) % NREQ;
         if (req[cand[IW-1:0]]) begin
            win_idx_d = cand[IW-1:0];
            win_vld_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; blocking stays in combinational code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         pad_i_q <= '0;
         pad_t_q <= 1'b1;
         busy_q  <= 1'b0;
         last_q  <= IW'(NREQ-1);
         turn_q  <= '0;
`ifdef TRI_BUS_TIMEOUT_EN
         hold_q  <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_vld_d) begin
                  state_q <= S_DRIVE;
                  gnt_q   <= NREQ'(1) << win_idx_d;
                  pad_i_q <= dat_a[win_idx_d];
                  pad_t_q <= 1'b0;
                  busy_q  <= 1'b1;
                  last_q  <= win_idx_d;
`ifdef TRI_BUS_TIMEOUT_EN
                  hold_q  <= 8'd1;
`endif
               end
            end
            S_DRIVE: begin
               if (drive_stop) begin
                  state_q <= S_TURN;
                  gnt_q   <= '0;
                  pad_i_q <= '0;
                  pad_t_q <= 1'b1;
                  turn_q  <= '0;
               end else begin
                  pad_i_q <= dat_a[last_q];
`ifdef TRI_BUS_TIMEOUT_EN
                  hold_q  <= hold_q + 8'd1;
`endif
               end
            end
            S_TURN: begin
               if (turn_q == TW'(TURN-1)) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  turn_q  <= turn_q + TW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               gnt_q   <= '0;
               pad_i_q <= '0;
               pad_t_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt   = gnt_q;
   assign pad_i = pad_i_q;
   assign pad_t = pad_t_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: directed scenarios plus randomized traffic against a
// cycle-level behavioural model; timeout scenario runs only when TRI_BUS_TIMEOUT_EN is defined.
module tb_tri_bus_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 8;
   localparam int TURN    = 2;
   localparam int MAXHOLD = 16;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] dat = '0;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      pad_i;
   logic                  pad_t;
   logic                  busy;

   int checks = 0;
   int errors = 0;

   // Behavioural model: owner index (-1 = none), remaining hi-Z turnaround cycles.
   int               m_owner;
   int               m_turn_left;
   int               m_last;
   int               m_hold;
   logic [WIDTH-1:0] m_pad;

   tri_bus_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .TURN(TURN), .MAXHOLD(MAXHOLD)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .dat(dat),
      .gnt(gnt), .pad_i(pad_i), .pad_t(pad_t), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_owner     = -1;
      m_turn_left = 0;
      m_last      = NREQ - 1;
      m_hold      = 0;
      m_pad       = '0;
   endtask

   task automatic model_step();
      if (rst) begin
         model_reset();
      end else if (m_owner >= 0) begin
         bit stop;
         stop = (req[m_owner] == 1'b0);
`ifdef TRI_BUS_TIMEOUT_EN
         if (m_hold >= MAXHOLD) stop = 1'b1;
`endif
         if (stop) begin
            m_owner     = -1;
            m_turn_left = TURN;
            m_pad       = '0;
         end else begin
            m_pad  = dat[m_owner*WIDTH +: WIDTH];
            m_hold = m_hold + 1;
         end
      end else if (m_turn_left > 0) begin
         m_turn_left = m_turn_left - 1;
      end else if (req != '0) begin
         for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last + k) % NREQ;
            if (req[c]) begin
               m_owner = c;
               break;
            end
         end
         m_last = m_owner;
         m_hold = 1;
         m_pad  = dat[m_owner*WIDTH +: WIDTH];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '1;
      dat = $urandom;
      tick();
      checks++;
      if (gnt !== '0)     begin errors++; $display("FAIL reset_gnt got=%b want=0", gnt); end
      checks++;
      if (pad_t !== 1'b1) begin errors++; $display("FAIL reset_pad_t got=%b want=1", pad_t); end
      checks++;
      if (pad_i !== '0)   begin errors++; $display("FAIL reset_pad_i got=%h want=0", pad_i); end
      checks++;
      if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      rst = 1'b0;
      req = '0;
      tick();
   endtask

   task automatic test_handover();
      logic [NREQ-1:0] exp_gnt  [6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
      logic            exp_t    [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic            exp_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      do_reset();
      dat = 32'hC3B2_A190;
      req = 4'b0101;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 1) req = 4'b0100;
         checks++;
         if (gnt !== exp_gnt[i] || pad_t !== exp_t[i] || busy !== exp_busy[i]) begin
            errors++;
            $display("FAIL handover_c%0d got gnt=%b t=%b busy=%b want gnt=%b t=%b busy=%b",
                     i, gnt, pad_t, busy, exp_gnt[i], exp_t[i], exp_busy[i]);
         end
      end
      checks++;
      if (pad_i !== 8'hB2) begin errors++; $display("FAIL handover_pad_i got=%h want=b2", pad_i); end
      req = '0;
      repeat (6) tick();
   endtask

   task automatic test_round_robin();
      int hiz;
      int own;
      do_reset();
      dat = $urandom;
      req = 4'b1111;
      tick();
      for (int g = 0; g < 5; g++) begin
         own = g % NREQ;
         checks++;
         if (gnt !== (NREQ'(1) << own)) begin
            errors++;
            $display("FAIL rr_order_%0d got=%b want=%b", g, gnt, NREQ'(1) << own);
         end
         if (g == 4) break;
         tick();
         tick();
         req[own] = 1'b0;
         hiz = 0;
         for (int n = 0; n < 20; n++) begin
            tick();
            if (n == 0) req[own] = 1'b1;
            if (gnt !== '0) break;
            if (pad_t === 1'b1) hiz++;
         end
         checks++;
         if (hiz != TURN + 1) begin
            errors++;
            $display("FAIL rr_hiz_%0d got=%0d want=%0d", g, hiz, TURN + 1);
         end
      end
      req = '0;
      repeat (6) tick();
   endtask

   task automatic test_data_follow();
      do_reset();
      dat = 32'h5A11_A5C3;
      req = 4'b0100;
      tick();
      checks++;
      if (gnt !== 4'b0100 || pad_i !== 8'h11) begin
         errors++;
         $display("FAIL data_first got gnt=%b pad=%h want gnt=0100 pad=11", gnt, pad_i);
      end
      dat[2*WIDTH +: WIDTH] = 8'h22;
      #1;
      checks++;
      if (pad_i !== 8'h11) begin errors++; $display("FAIL data_latency got=%h want=11", pad_i); end
      tick();
      checks++;
      if (pad_i !== 8'h22) begin errors++; $display("FAIL data_follow got=%h want=22", pad_i); end
      req = '0;
      repeat (6) tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      dat = $urandom;
      req = 4'b0100;
      tick();
      req = 4'b1110;
      tick();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (pad_t !== 1'b1 || gnt !== '0 || pad_i !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got t=%b gnt=%b pad=%h busy=%b want t=1 gnt=0 pad=0 busy=0",
                  pad_t, gnt, pad_i, busy);
      end
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (gnt !== 4'b0010) begin errors++; $display("FAIL async_restart got=%b want=0010", gnt); end
      req = '0;
      repeat (6) tick();
   endtask

`ifdef TRI_BUS_TIMEOUT_EN
   task automatic test_timeout();
      int cnt;
      int hiz;
      do_reset();
      dat = $urandom;
      req = 4'b0011;
      tick();
      cnt = 0;
      for (int n = 0; n < 300 && gnt === 4'b0001; n++) begin
         cnt++;
         tick();
      end
      checks++;
      if (cnt != MAXHOLD) begin errors++; $display("FAIL timeout_hold got=%0d want=%0d", cnt, MAXHOLD); end
      hiz = 0;
      for (int n = 0; n < 20 && gnt === '0; n++) begin
         if (pad_t === 1'b1) hiz++;
         tick();
      end
      checks++;
      if (hiz != TURN + 1 || gnt !== 4'b0010) begin
         errors++;
         $display("FAIL timeout_next got hiz=%0d gnt=%b want hiz=%0d gnt=0010", hiz, gnt, TURN + 1);
      end
      req = '0;
      repeat (40) tick();
   endtask
`endif

   task automatic test_random();
      logic [NREQ-1:0] e_gnt;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(499) == 0);
         for (int b = 0; b < NREQ; b++) begin
            if ($urandom_range(3) == 0) req[b] = ~req[b];
         end
         dat = $urandom;
         tick();
         e_gnt = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
         checks++;
         if (gnt !== e_gnt) begin errors++; $display("FAIL rand_gnt c%0d got=%b want=%b", cyc, gnt, e_gnt); end
         checks++;
         if (pad_t !== (m_owner < 0)) begin
            errors++; $display("FAIL rand_pad_t c%0d got=%b want=%b", cyc, pad_t, m_owner < 0);
         end
         checks++;
         if (pad_i !== m_pad) begin errors++; $display("FAIL rand_pad_i c%0d got=%h want=%h", cyc, pad_i, m_pad); end
         checks++;
         if (busy !== (m_owner >= 0 || m_turn_left > 0)) begin
            errors++; $display("FAIL rand_busy c%0d got=%b want=%b", cyc, busy, m_owner >= 0 || m_turn_left > 0);
         end
         checks++;
         if (pad_t === 1'b0 && gnt === '0) begin
            errors++; $display("FAIL rand_driven_without_grant c%0d got t=0 gnt=0 want t=1", cyc);
         end
      end
      rst = 1'b0;
      req = '0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_handover();
      test_round_robin();
      test_data_follow();
      test_async_reset();
`ifdef TRI_BUS_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tri_bus_arbiter.md
TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, number of pad bits in the shared tristate group (1..32).
REQ-003 Parameter TURN, default 2, hi-Z turnaround cycles between owners (1..15).
REQ-004 Parameter MAXHOLD, default 16, maximum consecutive drive cycles per grant (1..255).
REQ-005 The clock port SHALL be clk, input, 1 bit; all state changes on its rising edge.
REQ-006 The reset port SHALL be rst, input, 1 bit; asynchronous, active-high.
REQ-007 req, input, NREQ bits: bit n high = requester n wants the bus.
REQ-008 dat, input, NREQ*WIDTH bits: slice n is requester n's drive data.
REQ-009 gnt, output, NREQ bits: one-hot or zero; bit n high = requester n owns the bus.
REQ-010 pad_i, output, WIDTH bits: data to the pad buffers' I inputs.
REQ-011 pad_t, output, 1 bit: to the pad buffers' T inputs; 1 = hi-Z (pad pulled down), 0 = driven.
REQ-012 busy, output, 1 bit: high in DRIVE and TURN states.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, DRIVE, TURN; all outputs registered.
REQ-014 In IDLE with req nonzero, the block SHALL select the winner by round-robin and enter DRIVE next cycle.
REQ-015 The round-robin search SHALL start at index (last_owner+1) mod NREQ and wrap upward.
REQ-016 On entry to DRIVE, gnt SHALL show the one-hot winner, pad_t SHALL be 0, and pad_i SHALL equal the winner's dat slice sampled in the decision cycle.
REQ-017 In DRIVE, pad_i SHALL update every cycle from the owner's dat slice (one cycle latency).
REQ-018 DRIVE SHALL exit to TURN on the first cycle the owner's req is sampled low.
REQ-019 In TURN and IDLE, pad_t SHALL be 1, pad_i SHALL be all zeros, and gnt SHALL be zero.
REQ-020 TURN SHALL last exactly TURN cycles, then go to IDLE; a new grant therefore follows after at least TURN+1 hi-Z cycles.
REQ-021 Requests from non-owners during DRIVE or TURN SHALL be held off and not lost while req stays high.
REQ-022 Requests that drop before the IDLE decision cycle SHALL be ignored.
REQ-023 pad_t SHALL never be 0 while gnt is zero, and pad_t SHALL never be 0 in two consecutive grants without an intervening TURN.

Reset
REQ-024 On rst high: state = IDLE, gnt = 0, pad_t = 1, pad_i = 0, busy = 0, last_owner = NREQ-1, hold counter = 0, turn counter = 0; effective immediately, independent of clk.
REQ-025 Reset asserted mid-DRIVE SHALL release the pads (pad_t = 1) asynchronously; after reset release, arbitration restarts at requester 0.

Configuration
REQ-026 Macro TRI_BUS_TIMEOUT_EN: when defined, a hold counter SHALL force DRIVE to TURN after MAXHOLD drive cycles even with the owner's req high; the owner then re-competes in round-robin order.
REQ-027 Without TRI_BUS_TIMEOUT_EN, the owner SHALL hold DRIVE indefinitely while its req stays high, and no hold counter SHALL be implemented.

Verification
REQ-028 After reset, req=4'b0101 held -> gnt=0001 one cycle later, pad_t=0; after req[0] drops, 2 TURN cycles pad_t=1, then 1 IDLE cycle, then gnt=0100.
REQ-029 req=4'b1111 held continuously, timeout disabled, each owner drops req after 3 cycles -> grant order 0,1,2,3,0; every handover has exactly 3 pad_t=1 cycles.
REQ-030 TRI_BUS_TIMEOUT_EN, MAXHOLD=16, req=4'b0011 held -> requester 0 drives exactly 16 cycles, TURN, then requester 1 is granted.
REQ-031 Owner 2 dat changes 0x11 -> 0x22 at cycle k -> pad_i shows 0x22 at cycle k+1.
REQ-032 rst pulsed mid-DRIVE, between clk edges -> pad_t=1, gnt=0, pad_i=0 before the next edge; first grant after release goes to the lowest requesting index.
